// File: rtl/exc_collect.sv
// Exception-tagging pipeline feeding CP0: one record per instruction from D to W,
// where the earliest detected exception wins and W is presented directly to CP0.
module exc_collect #(
  parameter int unsigned PC_W     = 32,
  parameter logic [4:0]  INT_CODE = 5'd0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            en_d,
  input  logic            en_e,
  input  logic            en_m,
  input  logic            en_w,
  input  logic            if_valid,
  input  logic [PC_W-1:0] if_pc,
  input  logic            id_ri,
  input  logic            id_sys,
  input  logic            id_bp,
  input  logic            id_eret,
  input  logic            id_is_branch,
  input  logic            ex_ov,
  input  logic            mem_load,
  input  logic            mem_store,
  input  logic [1:0]      mem_size,
  input  logic [PC_W-1:0] mem_addr,
  input  logic            exc_occur,
  output logic            mem_kill,
  output logic            cp0_valid,
  output logic [PC_W-1:0] cp0_pc,
  output logic [PC_W-1:0] cp0_badvaddr,
  output logic [4:0]      cp0_exccode,
  output logic            cp0_is_exc,
  output logic            cp0_is_in_ds,
  output logic            cp0_is_eret
);

  localparam logic [4:0] C_ADEL = 5'd4;
  localparam logic [4:0] C_ADES = 5'd5;
  localparam logic [4:0] C_SYS  = 5'd8;
  localparam logic [4:0] C_BP   = 5'd9;
  localparam logic [4:0] C_RI   = 5'd10;
  localparam logic [4:0] C_OV   = 5'd12;

  typedef struct packed {
    logic            valid;
    logic [PC_W-1:0] pc;
    logic            exc;
    logic [4:0]      code;
    logic [PC_W-1:0] badvaddr;
    logic            ds;
    logic            eret;
  } rec_t;

  rec_t r_d, r_e, r_m, r_w;
  rec_t w_d_nxt, w_e_nxt, w_m_nxt, w_w_nxt;
  logic w_mis;
  logic w_dae;

  // Bubbles carry no flags so an invalid W never shows a stale exception.
  function automatic rec_t f_pass(input rec_t src, input logic v);
    rec_t r;
    r       = src;
    r.valid = v;
    if (!v) begin
      r.exc  = 1'b0;
      r.ds   = 1'b0;
      r.eret = 1'b0;
    end
    return r;
  endfunction

  always_comb begin
    w_mis = ((mem_size == 2'd1) & mem_addr[0]) |
            ((mem_size == 2'd2) & (mem_addr[1:0] != 2'b00));
    w_dae = (mem_load | mem_store) & w_mis;
  end

  assign mem_kill = r_m.valid & (r_m.exc | w_dae);

  always_comb begin
    w_d_nxt          = '0;
    w_d_nxt.valid    = if_valid;
    w_d_nxt.pc       = if_pc;
    w_d_nxt.badvaddr = if_pc;
    w_d_nxt.ds       = if_valid & r_d.valid & id_is_branch;
    if (if_valid & (if_pc[1:0] != 2'b00)) begin
      w_d_nxt.exc  = 1'b1;
      w_d_nxt.code = C_ADEL;
    end
  end

  always_comb begin
    w_e_nxt = f_pass(r_d, r_d.valid & en_d);
    if (w_e_nxt.valid & ~w_e_nxt.exc) begin
      if (id_ri) begin
        w_e_nxt.exc  = 1'b1;
        w_e_nxt.code = C_RI;
      end else if (id_sys) begin
        w_e_nxt.exc  = 1'b1;
        w_e_nxt.code = C_SYS;
      end else if (id_bp) begin
        w_e_nxt.exc  = 1'b1;
        w_e_nxt.code = C_BP;
      end else if (id_eret) begin
        w_e_nxt.exc  = 1'b1;
        w_e_nxt.eret = 1'b1;
        w_e_nxt.code = INT_CODE;
      end
    end
  end

  always_comb begin
    w_m_nxt = f_pass(r_e, r_e.valid & en_e);
    if (w_m_nxt.valid & ~w_m_nxt.exc & ex_ov) begin
      w_m_nxt.exc  = 1'b1;
      w_m_nxt.code = C_OV;
    end
  end

  always_comb begin
    w_w_nxt = f_pass(r_m, r_m.valid & en_m);
    if (w_w_nxt.valid & ~w_w_nxt.exc & w_dae) begin
      w_w_nxt.exc      = 1'b1;
      w_w_nxt.code     = mem_load ? C_ADEL : C_ADES;
      w_w_nxt.badvaddr = mem_addr;
    end
  end

  // Flush only needs valid/exc/ds/eret cleared; clearing everything keeps it identical to reset.
  always_ff @(posedge clk) begin
    if (reset | exc_occur) begin
      r_d <= '0;
      r_e <= '0;
      r_m <= '0;
      r_w <= '0;
    end else begin
      if (en_d) r_d <= w_d_nxt;
      if (en_e) r_e <= w_e_nxt;
      if (en_m) r_m <= w_m_nxt;
      if (en_w) r_w <= w_w_nxt;
    end
  end

  assign cp0_valid    = r_w.valid;
  assign cp0_pc       = r_w.pc;
  assign cp0_badvaddr = r_w.badvaddr;
  assign cp0_exccode  = r_w.code;
  assign cp0_is_exc   = r_w.exc;
  assign cp0_is_in_ds = r_w.ds;
  assign cp0_is_eret  = r_w.eret;

endmodule

// File: tb/tb_exc_collect.sv
// Bench for exc_collect: directed vector table, hand-written multi-cycle sequences,
// and randomized traffic checked against a stage-array reference model.
module tb_exc_collect;

  logic        clk = 1'b0;
  logic        reset, en_d, en_e, en_m, en_w, if_valid;
  logic [31:0] if_pc;
  logic        id_ri, id_sys, id_bp, id_eret, id_is_branch, ex_ov;
  logic        mem_load, mem_store;
  logic [1:0]  mem_size;
  logic [31:0] mem_addr;
  logic        exc_occur;
  logic        mem_kill, cp0_valid, cp0_is_exc, cp0_is_in_ds, cp0_is_eret;
  logic [31:0] cp0_pc, cp0_badvaddr;
  logic [4:0]  cp0_exccode;

  exc_collect #(.PC_W(32), .INT_CODE(5'd0)) dut (
    .clk(clk), .reset(reset),
    .en_d(en_d), .en_e(en_e), .en_m(en_m), .en_w(en_w),
    .if_valid(if_valid), .if_pc(if_pc),
    .id_ri(id_ri), .id_sys(id_sys), .id_bp(id_bp), .id_eret(id_eret),
    .id_is_branch(id_is_branch), .ex_ov(ex_ov),
    .mem_load(mem_load), .mem_store(mem_store), .mem_size(mem_size), .mem_addr(mem_addr),
    .exc_occur(exc_occur), .mem_kill(mem_kill),
    .cp0_valid(cp0_valid), .cp0_pc(cp0_pc), .cp0_badvaddr(cp0_badvaddr),
    .cp0_exccode(cp0_exccode), .cp0_is_exc(cp0_is_exc),
    .cp0_is_in_ds(cp0_is_in_ds), .cp0_is_eret(cp0_is_eret)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    bit        rst;
    bit [3:0]  en;     // [0]=d [1]=e [2]=m [3]=w
    bit        ifv;
    bit [31:0] ifpc;
    bit        ri, sys, bp, er, br, ov, ld, st;
    bit [1:0]  sz;
    bit [31:0] addr;
    bit        fl;
  } in_t;

  typedef struct packed {
    bit        v;
    bit [31:0] pc;
    bit        exc;
    bit [4:0]  code;
    bit [31:0] bva;
    bit        ds;
    bit        er;
  } rec_t;

  typedef struct packed {
    in_t  i;
    bit   kill;
    rec_t e;
  } vec_t;

  int   n_vec = 0;
  int   n_err = 0;
  rec_t m [4];
  logic s_kill;
  bit   mk_pre;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic in_t idle();
    in_t x;
    x    = '0;
    x.en = 4'hF;
    return x;
  endfunction

  function automatic in_t fetch(input bit [31:0] pc);
    in_t x;
    x      = idle();
    x.ifv  = 1'b1;
    x.ifpc = pc;
    return x;
  endfunction

  function automatic rec_t ex_rec(input bit [31:0] pc, input bit exc, input bit [4:0] code,
                                  input bit [31:0] bva, input bit ds, input bit er);
    rec_t r;
    r.v = 1'b1; r.pc = pc; r.exc = exc; r.code = code; r.bva = bva; r.ds = ds; r.er = er;
    return r;
  endfunction

  function automatic bit data_mis(input in_t x);
    int unsigned bytes;
    bytes = 1 << x.sz;
    return (x.ld || x.st) && (x.sz <= 2) && ((x.addr % bytes) != 0);
  endfunction

  // Candidate exceptions for the record entering stage k, highest priority first.
  function automatic void detect(input int k, input in_t x, inout rec_t r);
    int unsigned cand[$];
    case (k)
      0: if ((x.ifpc % 4) != 0) cand.push_back(4);
      1: begin
        if (x.ri)  cand.push_back(10);
        if (x.sys) cand.push_back(8);
        if (x.bp)  cand.push_back(9);
        if (x.er)  cand.push_back(99);
      end
      2: if (x.ov) cand.push_back(12);
      default: if (data_mis(x)) cand.push_back(x.ld ? 4 : 5);
    endcase
    if (cand.size() > 0 && r.v && !r.exc) begin
      r.exc = 1'b1;
      if (cand[0] == 99) begin
        r.er   = 1'b1;
        r.code = 5'd0;
      end else begin
        r.code = 5'(cand[0]);
      end
      if (k == 0) r.bva = x.ifpc;
      if (k == 3) r.bva = x.addr;
    end
  endfunction

  function automatic bit model_kill(input in_t x);
    return m[2].v && (m[2].exc || data_mis(x));
  endfunction

  task automatic model_step(input in_t x);
    rec_t n [4];
    for (int k = 0; k < 4; k++) n[k] = m[k];
    if (x.rst || x.fl) begin
      for (int k = 0; k < 4; k++) n[k] = '0;
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (x.en[k]) begin
          if (k == 0) begin
            n[0]    = '0;
            n[0].v  = x.ifv;
            n[0].pc = x.ifpc;
            n[0].ds = x.ifv & m[0].v & x.br;
          end else begin
            n[k]   = m[k-1];
            n[k].v = m[k-1].v & x.en[k-1];
          end
          if (!n[k].v) begin
            n[k].exc = 1'b0;
            n[k].ds  = 1'b0;
            n[k].er  = 1'b0;
          end
          detect(k, x, n[k]);
        end
      end
    end
    for (int k = 0; k < 4; k++) m[k] = n[k];
  endtask

  task automatic drive(input in_t x);
    reset = x.rst; en_d = x.en[0]; en_e = x.en[1]; en_m = x.en[2]; en_w = x.en[3];
    if_valid = x.ifv; if_pc = x.ifpc;
    id_ri = x.ri; id_sys = x.sys; id_bp = x.bp; id_eret = x.er; id_is_branch = x.br;
    ex_ov = x.ov; mem_load = x.ld; mem_store = x.st; mem_size = x.sz; mem_addr = x.addr;
    exc_occur = x.fl;
  endtask

  task automatic cycle(input in_t x);
    drive(x);
    #2;
    s_kill = mem_kill;
    mk_pre = model_kill(x);
    @(posedge clk);
    #1;
    model_step(x);
  endtask

  task automatic check_out(input rec_t e, input string nm);
    chk({nm, " valid"}, cp0_valid, e.v);
    if (e.v) begin
      chk({nm, " pc"}, cp0_pc, e.pc);
      chk({nm, " is_exc"}, cp0_is_exc, e.exc);
      chk({nm, " is_in_ds"}, cp0_is_in_ds, e.ds);
      chk({nm, " is_eret"}, cp0_is_eret, e.er);
      if (e.exc) chk({nm, " exccode"}, cp0_exccode, e.code);
      if (e.exc && (e.code == 5'd4 || e.code == 5'd5)) chk({nm, " badvaddr"}, cp0_badvaddr, e.bva);
    end
  endtask

  task automatic check_zero(input string nm);
    chk({nm, " z.valid"}, cp0_valid, 0);
    chk({nm, " z.pc"}, cp0_pc, 0);
    chk({nm, " z.badvaddr"}, cp0_badvaddr, 0);
    chk({nm, " z.exccode"}, cp0_exccode, 0);
    chk({nm, " z.is_exc"}, cp0_is_exc, 0);
    chk({nm, " z.is_in_ds"}, cp0_is_in_ds, 0);
    chk({nm, " z.is_eret"}, cp0_is_eret, 0);
    chk({nm, " z.mem_kill"}, mem_kill, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    vec_t tbl [9];
    in_t  x;
    rec_t none;
    none = '0;

    for (int i = 0; i < 9; i++) begin
      tbl[i].i    = idle();
      tbl[i].kill = 1'b0;
      tbl[i].e    = none;
    end
    tbl[0].i.rst = 1'b1;
    tbl[1].i     = fetch(32'h100);
    tbl[2].i     = fetch(32'h102);
    tbl[3].i     = fetch(32'h300);
    tbl[3].i.ri  = 1'b1;
    tbl[4].i     = fetch(32'h400);
    tbl[4].e     = ex_rec(32'h100, 0, 5'd0, 32'h0, 0, 0);
    tbl[5].i.er  = 1'b1;
    tbl[5].kill  = 1'b1;
    tbl[5].e     = ex_rec(32'h102, 1, 5'd4, 32'h102, 0, 0);
    tbl[6].i.ov  = 1'b1;
    tbl[6].i.st  = 1'b1;
    tbl[6].i.sz  = 2'd2;
    tbl[6].i.addr = 32'h2001;
    tbl[6].kill  = 1'b1;
    tbl[6].e     = ex_rec(32'h300, 1, 5'd5, 32'h2001, 0, 0);
    tbl[7].i.ld  = 1'b1;
    tbl[7].i.sz  = 2'd1;
    tbl[7].i.addr = 32'h11;
    tbl[7].kill  = 1'b1;
    tbl[7].e     = ex_rec(32'h400, 1, 5'd0, 32'h0, 0, 1);

    x = idle();
    x.rst = 1'b1;
    cycle(x);

    for (int i = 0; i < 9; i++) begin
      cycle(tbl[i].i);
      chk($sformatf("row%0d mem_kill", i), s_kill, tbl[i].kill);
      check_out(tbl[i].e, $sformatf("row%0d", i));
      if (tbl[i].i.rst) check_zero($sformatf("row%0d", i));
    end

    // Delay slot across a two-cycle D stall; E receives bubbles meanwhile.
    x = idle(); x.rst = 1'b1; cycle(x);
    cycle(fetch(32'h1F0));
    cycle(fetch(32'h200));
    for (int j = 0; j < 2; j++) begin
      x = fetch(32'h204); x.en[0] = 1'b0; x.br = 1'b1;
      cycle(x);
      chk("ds stall kill", s_kill, 0);
    end
    check_out(ex_rec(32'h1F0, 0, 5'd0, 0, 0, 0), "ds 1F0");
    x = fetch(32'h204); x.br = 1'b1;
    cycle(x);
    check_out(none, "ds bubble1");
    cycle(idle());
    check_out(none, "ds bubble2");
    cycle(idle());
    check_out(ex_rec(32'h200, 0, 5'd0, 0, 0, 0), "ds 200");
    cycle(idle());
    check_out(ex_rec(32'h204, 0, 5'd0, 0, 1, 0), "ds 204");
    cycle(idle());
    check_out(none, "ds drain");

    // Flush with an overflow record in W and three younger records behind it.
    cycle(fetch(32'h500));
    cycle(fetch(32'h504));
    x = fetch(32'h508); x.ov = 1'b1; cycle(x);
    cycle(fetch(32'h50C));
    check_out(ex_rec(32'h500, 1, 5'd12, 0, 0, 0), "flush pre");
    x = fetch(32'h510); x.fl = 1'b1;
    cycle(x);
    chk("flush pre kill", s_kill, 0);
    chk("flush valid", cp0_valid, 0);
    chk("flush is_exc", cp0_is_exc, 0);
    chk("flush is_eret", cp0_is_eret, 0);
    chk("flush is_in_ds", cp0_is_in_ds, 0);
    for (int j = 0; j < 3; j++) begin
      x = idle(); x.st = 1'b1; x.sz = 2'd2; x.addr = 32'h2001;
      cycle(x);
      chk($sformatf("flush kill%0d", j), s_kill, 0);
      chk($sformatf("flush drain%0d valid", j), cp0_valid, 0);
    end

    // Eret held in W under full stall, then reset mid-flow.
    cycle(fetch(32'h600));
    x = fetch(32'h604); x.er = 1'b1; cycle(x);
    cycle(fetch(32'h608));
    cycle(fetch(32'h60C));
    check_out(ex_rec(32'h600, 1, 5'd0, 0, 0, 1), "eret");
    for (int j = 0; j < 2; j++) begin
      x = idle(); x.en = 4'h0;
      cycle(x);
      chk($sformatf("eret hold%0d kill", j), s_kill, 0);
      check_out(ex_rec(32'h600, 1, 5'd0, 0, 0, 1), $sformatf("eret hold%0d", j));
    end
    x = fetch(32'h700); x.rst = 1'b1;
    cycle(x);
    x = idle(); x.st = 1'b1; x.sz = 2'd1; x.addr = 32'h3;
    drive(x);
    #1;
    check_zero("reset");
    for (int j = 0; j < 3; j++) begin
      cycle(x);
      chk($sformatf("reset drain%0d valid", j), cp0_valid, 0);
    end

    // Randomized traffic against the reference model.
    for (int t = 0; t < 3000; t++) begin
      int unsigned kind;
      x = idle();
      x.rst = ($urandom_range(0, 63) == 0);
      x.fl  = ($urandom_range(0, 19) == 0);
      for (int k = 0; k < 4; k++) x.en[k] = ($urandom_range(0, 4) != 0);
      x.ifv  = ($urandom_range(0, 3) != 0);
      x.ifpc = $urandom & 32'hFFFF_FFFC;
      if ($urandom_range(0, 7) == 0) x.ifpc[1:0] = 2'($urandom_range(1, 3));
      x.ri  = ($urandom_range(0, 11) == 0);
      x.sys = ($urandom_range(0, 11) == 0);
      x.bp  = ($urandom_range(0, 11) == 0);
      x.er  = ($urandom_range(0, 11) == 0);
      x.br  = ($urandom_range(0, 3) == 0);
      x.ov  = ($urandom_range(0, 7) == 0);
      kind  = $urandom_range(0, 3);
      x.ld  = (kind == 1);
      x.st  = (kind == 2);
      x.sz  = 2'($urandom_range(0, 2));
      x.addr = $urandom;
      cycle(x);
      chk($sformatf("rnd%0d mem_kill", t), s_kill, mk_pre);
      check_out(m[3], $sformatf("rnd%0d", t));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/exc_collect.md
Name: exc_collect

Overview:
Exception-tagging pipeline that sits directly upstream of the CP0 register file. It carries one exception record per instruction from decode to writeback. Each stage may raise an exception, and the earliest detection wins. At writeback it presents the pre_* interface that CP0 consumes: pc, excCode, is_exc, is_in_ds, is_eret and badvaddr. It also kills stores in MEM and flushes all records when CP0 reports exc_occur.

Parameters:
PC_W, 32, program-counter and address width
INT_CODE, 5'd0, ExcCode driven with eret records (CP0 requires is_exc=1 for eret)

Ports:
clk  in  1  clock
reset  in  1  synchronous reset, active-high
en_d/en_e/en_m/en_w  in  1 each  stage-register load enables from hazard unit
if_valid  in  1  fetched instruction valid
if_pc  in  PC_W  fetch pc
id_ri/id_sys/id_bp/id_eret  in  1 each  decode detections, qualify D-stage record
id_is_branch  in  1  D-stage instruction is branch/jump
ex_ov  in  1  arithmetic overflow, qualifies E-stage record
mem_load/mem_store  in  1 each  M-stage access type
mem_size  in  2  0=byte 1=half 2=word
mem_addr  in  PC_W  M-stage data address
exc_occur  in  1  from CP0; flush request
mem_kill  out  1  suppress M-stage memory write/read side-effects
cp0_valid  out  1  W record valid (CP0 reg_valid)
cp0_pc/cp0_badvaddr  out  PC_W  W record pc / faulting address
cp0_exccode  out  5  W record ExcCode
cp0_is_exc/cp0_is_in_ds/cp0_is_eret  out  1 each  W record flags

Behaviour:
- Record fields: valid, pc, exc, code[4:0], badvaddr, ds, eret. Four record registers: D, E, M, W.
- Reset: all valid, exc, ds and eret bits are 0; code=0; pc=0; badvaddr=0. All outputs are therefore 0 the cycle after reset.
- Flush: exc_occur=1 clears valid/exc/eret/ds in D, E, M and W at the next edge. Flush overrides every en_x. Fields other than those bits are don't-care.
- Load rule: stage k loads when en_k=1. Loaded valid = valid_(k-1) & en_(k-1).
  - If upstream is stalled while downstream advances, a bubble (valid=0) is inserted.
  - For D, the upstream is if_valid/if_pc, and en_d serves as both enables.
  - en_k=0 holds the stage.
- Detection is merged on load into the next stage. A record already carrying exc=1 is never overwritten, giving priority fetch AdEL > RI > Sys > Bp > eret > Ov > data AdEL/AdES.
- IF→D: if_pc[1:0]!=0 gives exc=1, code=4 (AdEL), badvaddr=if_pc.
- D→E, in order:
  - id_ri gives code=10.
  - id_sys gives code=8.
  - id_bp gives code=9.
  - id_eret gives exc=1, eret=1, code=INT_CODE.
- E→M: ex_ov gives code=12.
- M→W data address check:
  - Misalignment: half with mem_addr[0]=1, or word with mem_addr[1:0]!=0.
  - Load misaligned: code=4. Store misaligned: code=5. Both set badvaddr=mem_addr.
- Detections are ignored when the source record valid=0.
- Delay slot: on D load, ds = D.valid & id_is_branch, i.e. the instruction now leaving D was a branch. If en_d=1 but valid=0, ds=0.
- mem_kill is combinational: M.valid & (M.exc | data-address error this cycle).
- CP0 outputs are direct from the W register (cp0_is_exc = W.exc, etc.) with zero combinational logic. Latency is 4 enabled edges from fetch to cp0_valid.
- Simultaneous flush and stall: flush wins. A record stalled in W with exc=1 stays presented until exc_occur or en_w.

Test Plan:
- Clean flow: if_pc=0x100 aligned, all en=1 → after 4 edges cp0_valid=1, cp0_pc=0x100, cp0_is_exc=0, mem_kill never 1.
- Fetch AdEL beats RI: if_pc=0x102, id_ri=1 → cp0_exccode=4, cp0_badvaddr=0x102, cp0_is_exc=1.
- Data AdES: store, mem_size=2, mem_addr=0x2001 → mem_kill=1 that cycle; next cycle cp0_exccode=5, cp0_badvaddr=0x2001.
- Delay slot: branch at 0x200, then 0x204 → record 0x204 has cp0_is_in_ds=1 and 0x200 has 0. Stall en_d=0 for 2 cycles between them → still ds=1 for 0x204, and E gets bubbles.
- Flush: instruction with ex_ov in W plus 3 valid younger records; assert exc_occur → next cycle all valid=0, cp0_valid=0, mem_kill=0.
- Eret/reset: id_eret record → cp0_is_eret=1, cp0_is_exc=1, cp0_exccode=0. Assert reset mid-flow → all outputs 0 next cycle.
